// File: rtl/breakout_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the breakout ball logic.
// All coordinates are handled as 11-bit unsigned values so that stepping near zero never wraps.
package breakout_pkg;

    typedef logic [10:0] coord_t;

    localparam coord_t BALL_WIDTH     = 11'd5;
    localparam coord_t HALF           = BALL_WIDTH / 11'd2;
    localparam coord_t SPEED          = 11'd2;
    localparam coord_t WALL_LEFT      = 11'd8;
    localparam coord_t WALL_RIGHT     = 11'd631;
    localparam coord_t WALL_TOP       = 11'd8;
    localparam coord_t SCREEN_H       = 11'd480;
    localparam coord_t PADDLE_Y       = 11'd440;
    localparam coord_t PADDLE_WIDTH   = 11'd48;
    localparam coord_t PADDLE_X_RESET = 11'd320;

    // Ball-centre limits derived from the walls, paddle and screen bottom.
    localparam coord_t X_MIN        = WALL_LEFT + HALF;
    localparam coord_t X_MAX        = WALL_RIGHT - HALF;
    localparam coord_t Y_MIN        = WALL_TOP + HALF;
    localparam coord_t Y_REST       = PADDLE_Y - HALF - 11'd1;
    localparam coord_t Y_PADDLE     = PADDLE_Y - HALF;
    localparam coord_t Y_LOST       = SCREEN_H - 11'd1 - HALF;
    localparam coord_t PADDLE_REACH = PADDLE_WIDTH / 11'd2 + HALF;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

    localparam logic [1:0] ST_HELD   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_LOST   = 2'd2;

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis combinational step with reflection at the lo/hi limits.
// dir = DIR_POS moves toward increasing coordinates.
module ball_axis_step
    import breakout_pkg::*;
(
    input  logic [10:0] pos,
    input  logic        dir,
    input  logic [10:0] lo,
    input  logic [10:0] hi,
    input  logic [10:0] speed,
    output logic [10:0] next_pos,
    output logic        next_dir,
    output logic        hit_lo,
    output logic        hit_hi
);

    // Step by speed, clamping to the limit and reversing when it would be crossed.
    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit_lo   = 1'b0;
        hit_hi   = 1'b0;
        if (dir == DIR_NEG) begin
            if (pos < lo + speed) begin
                next_pos = lo;
                next_dir = DIR_POS;
                hit_lo   = 1'b1;
            end else begin
                next_pos = pos - speed;
            end
        end else begin
            if (pos + speed > hi) begin
                next_pos = hi;
                next_dir = DIR_NEG;
                hit_hi   = 1'b1;
            end else begin
                next_pos = pos + speed;
            end
        end
    end

endmodule

// File: rtl/ball_controller.sv
// Per-frame ball position update: held on the paddle, moving with wall/paddle/brick
// reflection, and a one-cycle lost pulse when the ball passes the paddle.
module ball_controller
    import breakout_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit_h,
    input  logic       brick_hit_v,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       moving,
    output logic       ball_lost
);

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic       hit_h_q, hit_h_d;
    logic       hit_v_q, hit_v_d;
    logic       moving_q, moving_d;
    logic       ball_lost_q, ball_lost_d;

    logic       hit_h_s, hit_v_s;
    logic       dx_eff_s, dy_eff_s;
    coord_t     x_ext_s, y_ext_s, paddle_ext_s;
    coord_t     x_step_s, y_step_s;
    logic       x_dir_s, y_dir_s;
    logic       x_hit_lo_s, x_hit_hi_s, y_hit_lo_s, y_hit_hi_s;
    logic       paddle_bounce_s;
    logic       unused_bits_s;

    // A hit in the same cycle as frame_tick still counts for that update.
    assign hit_h_s      = hit_h_q | brick_hit_h;
    assign hit_v_s      = hit_v_q | brick_hit_v;
    assign dx_eff_s     = dx_q ^ hit_h_s;
    assign dy_eff_s     = dy_q ^ hit_v_s;
    assign x_ext_s      = {1'b0, x_q};
    assign y_ext_s      = {2'b00, y_q};
    assign paddle_ext_s = {1'b0, paddle_x};

    ball_axis_step u_step_x (
        .pos      (x_ext_s),
        .dir      (dx_eff_s),
        .lo       (X_MIN),
        .hi       (X_MAX),
        .speed    (SPEED),
        .next_pos (x_step_s),
        .next_dir (x_dir_s),
        .hit_lo   (x_hit_lo_s),
        .hit_hi   (x_hit_hi_s)
    );

    // The y upper limit is the loss line; reaching it means the paddle was missed.
    ball_axis_step u_step_y (
        .pos      (y_ext_s),
        .dir      (dy_eff_s),
        .lo       (Y_MIN),
        .hi       (Y_LOST),
        .speed    (SPEED),
        .next_pos (y_step_s),
        .next_dir (y_dir_s),
        .hit_lo   (y_hit_lo_s),
        .hit_hi   (y_hit_hi_s)
    );

    assign unused_bits_s = ^{x_step_s[10], y_step_s[10:9], x_hit_lo_s, x_hit_hi_s, y_hit_lo_s};

    // Paddle overlap uses the pre-step x so the bounce matches what was painted.
    assign paddle_bounce_s = (dy_eff_s == DIR_POS)
                           && (y_ext_s < Y_PADDLE)
                           && ((y_ext_s + SPEED) >= Y_PADDLE)
                           && (abs_diff(x_ext_s, paddle_ext_s) <= PADDLE_REACH);

    // Next-state, position and direction; everything moves only on frame_tick.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hit_h_d = hit_h_s;
        hit_v_d = hit_v_s;
        if (frame_tick) begin
            hit_h_d = 1'b0;
            hit_v_d = 1'b0;
            case (state_q)
                ST_MOVING: begin
                    x_d  = x_step_s[9:0];
                    dx_d = x_dir_s;
                    if (paddle_bounce_s) begin
                        y_d  = 9'(Y_REST);
                        dy_d = DIR_NEG;
                        if (x_ext_s < paddle_ext_s) begin
                            dx_d = DIR_NEG;
                        end else if (x_ext_s > paddle_ext_s) begin
                            dx_d = DIR_POS;
                        end else begin
                            dx_d = x_dir_s;
                        end
                    end else begin
                        y_d  = y_step_s[8:0];
                        dy_d = y_dir_s;
                        if (y_hit_hi_s) begin
                            state_d = ST_LOST;
                        end else begin
                            state_d = ST_MOVING;
                        end
                    end
                end
                default: begin
                    // HELD and LOST both park the ball on the paddle; only HELD may launch.
                    x_d  = paddle_x;
                    y_d  = 9'(Y_REST);
                    dx_d = DIR_POS;
                    dy_d = DIR_NEG;
                    if ((state_q == ST_HELD) && launch) begin
                        state_d = ST_MOVING;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end else begin
            state_d = state_q;
        end
        moving_d    = (state_d == ST_MOVING);
        ball_lost_d = (state_d == ST_LOST) && (state_q != ST_LOST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HELD;
            x_q         <= 10'(PADDLE_X_RESET);
            y_q         <= 9'(Y_REST);
            dx_q        <= DIR_POS;
            dy_q        <= DIR_NEG;
            hit_h_q     <= 1'b0;
            hit_v_q     <= 1'b0;
            moving_q    <= 1'b0;
            ball_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hit_h_q     <= hit_h_d;
            hit_v_q     <= hit_v_d;
            moving_q    <= moving_d;
            ball_lost_q <= ball_lost_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign moving    = moving_q;
    assign ball_lost = ball_lost_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: vector table for held/launch/wall behaviour,
// hand sequences for paddle bounce, loss, brick hits and asynchronous reset.
module tb_ball_controller;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       frame_tick  = 1'b0;
    logic       launch      = 1'b0;
    logic [9:0] paddle_x    = 10'd320;
    logic       brick_hit_h = 1'b0;
    logic       brick_hit_v = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic       moving;
    logic       ball_lost;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic       launch;
        logic [9:0] paddle;
        logic       hh;
        logic       hv;
        logic [9:0] ex;
        logic [8:0] ey;
        logic       em;
    } vec_t;

    vec_t vecs [21];

    always #5 clk = ~clk;

    ball_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .launch      (launch),
        .paddle_x    (paddle_x),
        .brick_hit_h (brick_hit_h),
        .brick_hit_v (brick_hit_v),
        .x           (x),
        .y           (y),
        .moving      (moving),
        .ball_lost   (ball_lost)
    );

    function automatic vec_t mk(input logic r, input logic l, input int p, input logic hh,
                                input logic hv, input int ex, input int ey, input logic em);
        vec_t v;
        v.rst    = r;
        v.launch = l;
        v.paddle = 10'(p);
        v.hh     = hh;
        v.hv     = hv;
        v.ex     = 10'(ex);
        v.ey     = 9'(ey);
        v.em     = em;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey, input int em);
        chk({name, ".x"}, int'(x), ex);
        chk({name, ".y"}, int'(y), ey);
        chk({name, ".moving"}, int'(moving), em);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        brick_hit_h = 1'b0;
        brick_hit_v = 1'b0;
        frame_tick  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Optional brick pulses mid-frame, then one frame_tick; ends just after the update edge.
    task automatic tick(input logic hh, input logic hv);
        @(negedge clk);
        brick_hit_h = hh;
        brick_hit_v = hv;
        @(negedge clk);
        brick_hit_h = 1'b0;
        brick_hit_v = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_with_v();
        @(negedge clk);
        frame_tick  = 1'b1;
        brick_hit_v = 1'b1;
        @(negedge clk);
        frame_tick  = 1'b0;
        brick_hit_v = 1'b0;
    endtask

    // Launch at x=298 and climb to the top and back down to y=436 with x parked at 300, dx+.
    task automatic reach_436();
        do_reset();
        paddle_x = 10'd298;
        launch   = 1'b1;
        tick(1'b0, 1'b0);
        launch = 1'b0;
        repeat (426) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk_pos("pre_paddle", 300, 436, 1);
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 200, 1'b0, 1'b0, 200, 437, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 200, 1'b0, 1'b0, 200, 437, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 200, 1'b0, 1'b0, 200, 437, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 200, 1'b0, 1'b0, 200, 437, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 200, 1'b0, 1'b0, 202, 435, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 100, 1'b0, 1'b0, 204, 433, 1'b1);
        vecs[6]  = mk(1'b1, 1'b1, 620, 1'b0, 1'b0, 620, 437, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 622, 435, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 624, 433, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 626, 431, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 628, 429, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 629, 427, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 620, 1'b0, 1'b0, 627, 425, 1'b1);
        vecs[13] = mk(1'b1, 1'b1, 15,  1'b0, 1'b0, 15,  437, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 15,  1'b1, 1'b0, 13,  435, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 15,  1'b0, 1'b0, 11,  433, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 15,  1'b0, 1'b0, 10,  431, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 15,  1'b0, 1'b0, 12,  429, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 15,  1'b1, 1'b0, 10,  427, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 15,  1'b0, 1'b0, 10,  425, 1'b1);
        vecs[20] = mk(1'b0, 1'b0, 15,  1'b0, 1'b0, 12,  423, 1'b1);

        do_reset();
        chk_pos("reset", 320, 437, 0);
        chk("reset.ball_lost", int'(ball_lost), 0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            paddle_x = vecs[i].paddle;
            launch   = vecs[i].launch;
            tick(vecs[i].hh, vecs[i].hv);
            chk_pos($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey), int'(vecs[i].em));
        end
        launch = 1'b0;

        // Paddle bounce: ball left of paddle centre goes back up and heads left.
        reach_436();
        paddle_x = 10'd310;
        tick(1'b0, 1'b0);
        chk_pos("bounce", 302, 437, 1);
        tick(1'b0, 1'b0);
        chk_pos("bounce_next", 300, 435, 1);

        // Paddle too far away: ball continues down and is eventually lost.
        reach_436();
        paddle_x = 10'd340;
        tick(1'b0, 1'b0);
        chk_pos("no_bounce", 302, 438, 1);
        repeat (19) tick(1'b0, 1'b0);
        chk_pos("pre_loss", 340, 476, 1);
        tick(1'b0, 1'b0);
        chk_pos("loss", 342, 477, 0);
        chk("loss.ball_lost_hi", int'(ball_lost), 1);
        @(negedge clk);
        chk("loss.ball_lost_lo", int'(ball_lost), 0);
        paddle_x = 10'd150;
        launch   = 1'b1;
        tick(1'b0, 1'b0);
        chk_pos("lost_to_held", 150, 437, 0);
        chk("lost_to_held.ball_lost", int'(ball_lost), 0);
        tick(1'b0, 1'b0);
        chk_pos("relaunch", 150, 437, 1);
        launch = 1'b0;

        // Brick hits on a horizontal face: mid-frame pulse and same-cycle pulse.
        do_reset();
        paddle_x = 10'd200;
        launch   = 1'b1;
        tick(1'b0, 1'b0);
        launch = 1'b0;
        repeat (168) tick(1'b0, 1'b0);
        chk_pos("pre_brick", 536, 101, 1);
        tick(1'b0, 1'b1);
        chk_pos("brick_v", 538, 103, 1);
        tick(1'b0, 1'b0);
        chk_pos("brick_v_next", 540, 105, 1);
        tick_with_v();
        chk_pos("brick_v_same", 542, 103, 1);
        tick(1'b0, 1'b0);
        chk_pos("brick_v_cleared", 544, 101, 1);

        // Asynchronous reset mid-frame while moving, checked before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pos("async_reset", 320, 437, 0);
        chk("async_reset.ball_lost", int'(ball_lost), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
- Computes the ball centre position (x, y) once per video frame and feeds the ball painter.
- Holds the ball on the paddle until launch, then moves it at a fixed speed.
- Reflects the ball off the side walls, top wall, paddle and brick hits reported by the brick collision logic.
- Flags a lost ball when it passes the paddle; the score/lives logic consumes that flag.

Parameters:
BALL_WIDTH, 5, ball size in pixels; odd; HALF = BALL_WIDTH/2 = 2
SPEED, 2, pixels moved per frame on each axis
WALL_LEFT, 8, first playfield column
WALL_RIGHT, 631, last playfield column
WALL_TOP, 8, first playfield row
SCREEN_H, 480, visible rows
PADDLE_Y, 440, top row of the paddle
PADDLE_WIDTH, 48, paddle width in pixels; even
PADDLE_X_RESET, 320, paddle centre used at reset

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse at start of vertical blank
launch  input  1  level; releases the ball from the paddle
paddle_x  input  10  paddle centre column
brick_hit_h  input  1  one-cycle pulse; brick hit on a vertical face, flip dx
brick_hit_v  input  1  one-cycle pulse; brick hit on a horizontal face, flip dy
x  output  10  ball centre column, to painter
y  output  9  ball centre row, to painter
moving  output  1  high in MOVING
ball_lost  output  1  one-cycle pulse when the ball exits the bottom

Behaviour:
- Reset (async, rst_n low):
  - state = HELD; x = PADDLE_X_RESET; y = PADDLE_Y-HALF-1 (437).
  - dx = +, dy = -; moving = 0; ball_lost = 0; sticky hit flags cleared.
  - Reset mid-move abandons the motion immediately.
- Update timing: all position/direction updates occur only on the clk edge where frame_tick = 1. x/y are registered and constant for the rest of the frame, so the painter sees stable values for the whole active area.
- Brick hit flags:
  - brick_hit_h and brick_hit_v set sticky flags hit_h and hit_v at any cycle.
  - The flags are consumed and cleared on the frame_tick edge.
  - A hit arriving in the same cycle as frame_tick is consumed in that update.
- State HELD:
  - On each frame_tick: x = paddle_x, y = 437.
  - If launch = 1 at that tick, go to MOVING with dx = +, dy = -; position is not stepped that frame.
  - Hit flags are discarded.
- State MOVING, per frame_tick, in this order:
  1. If hit_h, flip dx. If hit_v, flip dy.
  2. X axis:
     - dx- and x-SPEED < WALL_LEFT+HALF (10): x = 10, dx = +.
     - dx+ and x+SPEED > WALL_RIGHT-HALF (629): x = 629, dx = -.
     - Otherwise x = x±SPEED.
  3. Y axis:
     - dy- and y-SPEED < WALL_TOP+HALF (10): y = 10, dy = +.
     - Paddle bounce when dy+, y < 438, y+SPEED >= 438, and |x-paddle_x| <= PADDLE_WIDTH/2+HALF (26), using pre-step x:
       - y = 437, dy = -.
       - dx = - if x < paddle_x; dx = + if x > paddle_x; unchanged if equal.
     - Loss when dy+ and y+SPEED > SCREEN_H-1-HALF (477): go to LOST, y = 477.
     - Otherwise y = y±SPEED.
- State LOST:
  - ball_lost pulses high for the single cycle after entry.
  - At the next frame_tick, go to HELD and apply HELD positioning.
  - launch is ignored while in LOST.
- launch is ignored in MOVING.
- Arithmetic: all comparisons use 11-bit unsigned with one guard bit, so x-SPEED near 0 never wraps.
- moving = (state == MOVING), registered.

Decomposition:
- breakout_pkg holds:
  - screen and wall constants;
  - BALL_WIDTH and HALF;
  - PADDLE_Y and PADDLE_WIDTH;
  - the state encoding HELD = 0, MOVING = 1, LOST = 2.
- Sub-module ball_axis_step is one-axis combinational step+reflect: pos, dir, lo, hi, speed -> next_pos, next_dir, hit_lo, hit_hi. It is instantiated once per axis.
- Paddle and loss checks stay in ball_controller.

Test Plan:
- Reset, then 3 frame_ticks with launch = 0, paddle_x = 200 -> x = 200, y = 437, moving = 0.
- launch = 1 at a tick, then one more tick -> moving = 1, x = 202, y = 435.
- MOVING at x = 11, dx-, tick -> x = 10, dx = +; next tick x = 12. Same test at right: x = 628, dx+ -> x = 629, dx = -.
- Ball at y = 436, dy+, x = 300, paddle_x = 310, tick -> y = 437, dy = -, dx = -. Repeat with paddle_x = 340 (|dx| = 40) -> no bounce, y = 438.
- Ball at y = 476, dy+, no paddle overlap, tick -> ball_lost high for exactly 1 cycle, state LOST; next tick -> HELD at paddle position.
- brick_hit_v pulse mid-frame at y = 100, dy-, then tick -> y = 102, dy = +. Separately, assert rst_n = 0 mid-frame while MOVING -> outputs return to reset values immediately, without waiting for a clk edge.
